// File: rtl/md_unit.sv
// Signed multi-cycle multiply/divide unit: radix-2 Booth MUL and non-restoring DIV,
// one bit per clock, producing the 64-bit Z result as zhigh/zlow.
//
// state | meaning
// IDLE  | waiting for start; zhigh/zlow/div_zero hold the last result
// RUN   | one Booth or division step per cycle, counter counts down to 0
// FIN   | result registered, done pulses, back to IDLE next cycle
module md_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   output logic [WIDTH-1:0] zhigh,
   output logic [WIDTH-1:0] zlow,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic             op_r;
   logic             sign_q;
   logic             sign_r;
   logic [WIDTH:0]   acc_a;
   logic [WIDTH:0]   m;
   logic [WIDTH-1:0] acc_q;
   logic             q_m1;

   logic [WIDTH:0]   a_step;
   logic [WIDTH:0]   r_shift;
   logic [WIDTH:0]   a_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic             qm1_nxt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic             div0;

   assign div0  = op & (opB == '0);
   assign abs_a = opA[WIDTH-1] ? -opA : opA;
   assign abs_b = opB[WIDTH-1] ? -opB : opB;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = div0 ? FIN : RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == '0) begin
               state_nxt = FIN;
            end
         end
         FIN: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // One iteration of the active algorithm, plus the corrected remainder magnitude
   // used when the last division step is retired.
   always_comb begin
      a_step  = acc_a;
      r_shift = '0;
      a_nxt   = acc_a;
      q_nxt   = acc_q;
      qm1_nxt = q_m1;
      if (!op_r) begin
         case ({acc_q[0], q_m1})
            2'b01:   a_step = acc_a + m;
            2'b10:   a_step = acc_a - m;
            default: a_step = acc_a;
         endcase
         {a_nxt, q_nxt, qm1_nxt} = {a_step[WIDTH], a_step, acc_q};
      end else begin
         r_shift = {acc_a[WIDTH-1:0], acc_q[WIDTH-1]};
         a_nxt   = acc_a[WIDTH] ? (r_shift + m) : (r_shift - m);
         q_nxt   = {acc_q[WIDTH-2:0], ~a_nxt[WIDTH]};
      end
      rem = a_nxt[WIDTH] ? (a_nxt[WIDTH-1:0] + m[WIDTH-1:0]) : a_nxt[WIDTH-1:0];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt      <= '0;
         op_r     <= 1'b0;
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
         acc_a    <= '0;
         acc_q    <= '0;
         m        <= '0;
         q_m1     <= 1'b0;
         zhigh    <= '0;
         zlow     <= '0;
         div_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_r     <= op;
                  div_zero <= div0;
                  cnt      <= CW'(WIDTH - 1);
                  q_m1     <= 1'b0;
                  acc_a    <= '0;
                  sign_q   <= opA[WIDTH-1] ^ opB[WIDTH-1];
                  sign_r   <= opA[WIDTH-1];
                  // DIV runs on magnitudes; MUL keeps the multiplicand sign-extended
                  if (op) begin
                     acc_q <= abs_a;
                     m     <= {1'b0, abs_b};
                  end else begin
                     acc_q <= opB;
                     m     <= {opA[WIDTH-1], opA};
                  end
                  if (div0) begin
                     zlow  <= '1;
                     zhigh <= opA;
                  end
               end
            end
            RUN: begin
               acc_a <= a_nxt;
               acc_q <= q_nxt;
               q_m1  <= qm1_nxt;
               cnt   <= cnt - CW'(1);
               if (cnt == '0) begin
                  if (!op_r) begin
                     zhigh <= a_nxt[WIDTH-1:0];
                     zlow  <= q_nxt;
                  end else begin
                     zlow  <= sign_q ? -q_nxt : q_nxt;
                     zhigh <= sign_r ? -rem : rem;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: table vectors, random vectors against a
// longint reference, and sequences for start-while-busy and reset mid-operation.
module tb_md_unit;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic [31:0] opA = '0;
   logic [31:0] opB = '0;
   logic [31:0] zhigh;
   logic [31:0] zlow;
   logic        busy;
   logic        done;
   logic        div_zero;

   always #5 clock = ~clock;

   md_unit #(.WIDTH(32)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (start),
      .op       (op),
      .opA      (opA),
      .opB      (opB),
      .zhigh    (zhigh),
      .zlow     (zlow),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          lat;
   } exp_t;

   typedef struct {
      logic        o;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   exp_t        sb[$];
   logic [31:0] prev_hi = '0;
   logic [31:0] prev_lo = '0;

   task automatic chk(input string tag, input string name, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s/%s actual=%0h required=%0h", tag, name, act, req);
      end
   endtask

   function automatic exp_t model(input logic o, input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      longint p;
      longint q;
      longint r;
      e.hi  = '0;
      e.lo  = '0;
      e.dz  = 1'b0;
      e.lat = 33;
      if (!o) begin
         p    = longint'($signed(a)) * longint'($signed(b));
         e.hi = p[63:32];
         e.lo = p[31:0];
      end else if (b == 32'h0) begin
         e.hi  = a;
         e.lo  = 32'hFFFF_FFFF;
         e.dz  = 1'b1;
         e.lat = 1;
      end else begin
         q    = longint'($signed(a)) / longint'($signed(b));
         r    = longint'($signed(a)) % longint'($signed(b));
         e.hi = r[31:0];
         e.lo = q[31:0];
      end
      return e;
   endfunction

   // Issues one operation and watches cycles 1..45 after the start cycle.
   // inject: cycle in which a competing start is driven (0 = none).
   // rst_at: cycle in which reset_n is pulsed low (0 = none).
   task automatic run(input logic o, input logic [31:0] a, input logic [31:0] b,
                      input exp_t e, input int inject, input int rst_at, input string tag);
      int   seen;
      int   busy_err;
      logic exp_busy;
      exp_t g;
      seen     = 0;
      busy_err = 0;
      @(negedge clock);
      start = 1'b1;
      op    = o;
      opA   = a;
      opB   = b;
      sb.push_back(e);
      @(posedge clock);
      #1;
      start = 1'b0;
      op    = ~o;
      opA   = $urandom;
      opB   = $urandom;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clock);
         start = (c == inject);
         if (c == inject) begin
            op  = ~o;
            opA = 32'h5;
            opB = 32'h3;
         end
         if (rst_at > 0 && c == rst_at) begin
            reset_n = 1'b0;
            #1;
            chk(tag, "rst_z", {zhigh, zlow}, 64'h0);
            chk(tag, "rst_flags", {29'h0, busy, done, div_zero}, 32'h0);
            sb.delete();
            prev_hi = '0;
            prev_lo = '0;
         end
         if (rst_at > 0 && c == rst_at + 1) reset_n = 1'b1;
         exp_busy = (rst_at == 0 || c < rst_at) && (c <= e.lat);
         if (busy !== exp_busy) busy_err++;
         if (c == 1 && e.lat > 1) chk(tag, "dz_clear", {63'h0, div_zero}, 64'h0);
         if (c == 20 && e.lat > 20 && (rst_at == 0 || rst_at > 20))
            chk(tag, "hold_run", {zhigh, zlow}, {prev_hi, prev_lo});
         if (done === 1'b1) begin
            seen++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL %s/spurious_done actual=cycle %0d required=no done", tag, c);
            end else begin
               g = sb.pop_front();
               chk(tag, "latency", 64'(c), 64'(g.lat));
               chk(tag, "zhigh", {32'h0, zhigh}, {32'h0, g.hi});
               chk(tag, "zlow", {32'h0, zlow}, {32'h0, g.lo});
               chk(tag, "div_zero", {63'h0, div_zero}, {63'h0, g.dz});
               prev_hi = g.hi;
               prev_lo = g.lo;
            end
         end
         if (c == 45 && seen > 0)
            chk(tag, "hold_idle", {31'h0, div_zero, zhigh, zlow}, {31'h0, e.dz, prev_hi, prev_lo});
      end
      chk(tag, "done_count", 64'(seen), (rst_at > 0) ? 64'h0 : 64'h1);
      chk(tag, "busy_trace", 64'(busy_err), 64'h0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t        vecs[10];
      exp_t        e;
      logic        o;
      logic [31:0] a;
      logic [31:0] b;

      vecs[0] = '{1'b0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
      vecs[1] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
      vecs[2] = '{1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0};
      vecs[3] = '{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      vecs[4] = '{1'b1, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
      vecs[5] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
      vecs[6] = '{1'b1, 32'h0000_1234, 32'h0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
      vecs[7] = '{1'b0, 32'h0,        32'h0001_2345, 32'h0,         32'h0,         1'b0};
      vecs[8] = '{1'b1, 32'd100,      32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0};
      vecs[9] = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E, 1'b0};

      #3;
      chk("reset", "z", {zhigh, zlow}, 64'h0);
      chk("reset", "flags", {61'h0, busy, done, div_zero}, 64'h0);
      @(negedge clock);
      reset_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         e.hi  = vecs[i].hi;
         e.lo  = vecs[i].lo;
         e.dz  = vecs[i].dz;
         e.lat = (vecs[i].o && vecs[i].b == 32'h0) ? 1 : 33;
         run(vecs[i].o, vecs[i].a, vecs[i].b, e, 0, 0, $sformatf("vec%0d", i));
      end

      for (int i = 0; i < 6; i++) begin
         o = 1'($urandom_range(0, 1));
         a = $urandom;
         b = ($urandom_range(0, 2) == 0) ? 32'($signed($urandom_range(0, 40)) - 20) : $urandom;
         run(o, a, b, model(o, a, b), 0, 0, $sformatf("rnd%0d", i));
      end

      run(1'b0, 32'd7, 32'hFFFF_FFFD, model(1'b0, 32'd7, 32'hFFFF_FFFD), 10, 0, "busy_start");
      run(1'b0, 32'h0001_2345, 32'h0000_0777, model(1'b0, 32'h0001_2345, 32'h0000_0777), 0, 15,
          "rst_mid");
      run(1'b1, 32'hFFFF_FF9C, 32'd7, model(1'b1, 32'hFFFF_FF9C, 32'd7), 0, 0, "post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
